// File: rtl/selector_pkg.sv
// Shared types and constants for the 3x3 board cursor controller.
// Latency: none (declarations only).
// Backpressure: not applicable.
package selector_pkg;

    localparam int N_CASILLAS = 9;

    typedef logic [3:0] casilla_t;

    typedef enum logic {
        SELECCION = 1'b0,
        PENDIENTE = 1'b1
    } estado_t;

endpackage

// File: rtl/selector_casilla_antirrebote.sv
// Pushbutton conditioner: 2-flop synchronizer, debounce counter, rising-edge pulse.
// Latency: pulse is high DEBOUNCE_CYCLES+2 cycles after the first stage-1 high sample.
// Backpressure: none; one pulse per accepted press, falling edges are silent.
module antirrebote #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_boton,
    output logic o_pulso
);

    // Counter only needs to reach DEBOUNCE_CYCLES-1 before it clears.
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sinc1;
    logic          r_sinc2;
    logic          r_aceptado;
    logic          r_aceptado_d;
    logic          r_pulso;
    logic [CW-1:0] r_cnt;

    // Synchronize, debounce against the accepted level, and register the rising edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sinc1      <= 1'b0;
            r_sinc2      <= 1'b0;
            r_aceptado   <= 1'b0;
            r_aceptado_d <= 1'b0;
            r_pulso      <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_sinc1 <= i_boton;
            r_sinc2 <= r_sinc1;
            if (r_sinc2 == r_aceptado) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                r_aceptado <= ~r_aceptado;
                r_cnt      <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_aceptado_d <= r_aceptado;
            r_pulso      <= r_aceptado & ~r_aceptado_d;
        end
    end

    assign o_pulso = r_pulso;

endmodule

// File: rtl/selector_casilla.sv
// Board cursor: debounced move/select buttons drive a 0-8 cell index skipping taken cells.
// Latency: contador/jugada_valida update DEBOUNCE_CYCLES+3 edges after the stage-1 sample.
// Backpressure: a confirmed move is held until jugada_ack; button pulses are dropped meanwhile.
module selector_casilla
    import selector_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       boton_rst,
    input  logic       boton_mover,
    input  logic       boton_selec,
    input  logic [8:0] ocupadas,
    input  logic       jugada_ack,
    output logic [3:0] contador,
    output logic       jugada_valida,
    output logic [3:0] casilla_jugada
);

    logic     w_p_mover;
    logic     w_p_selec;
    estado_t  r_estado;
    estado_t  w_estado_sig;
    casilla_t r_contador;
    casilla_t w_contador_sig;
    logic     r_valida;
    logic     w_valida_sig;
    casilla_t r_casilla;
    casilla_t w_casilla_sig;

    antirrebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ar_mover (
        .i_clk   (clk),
        .i_rst_n (boton_rst),
        .i_boton (boton_mover),
        .o_pulso (w_p_mover)
    );

    antirrebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ar_selec (
        .i_clk   (clk),
        .i_rst_n (boton_rst),
        .i_boton (boton_selec),
        .o_pulso (w_p_selec)
    );

    // First free cell after cur, wrapping 8->0; cur itself is returned when none is free.
    function automatic casilla_t siguiente_libre(input casilla_t cur, input logic [8:0] occ);
        casilla_t   res;
        logic       hallado;
        logic [4:0] idx;
        res     = cur;
        hallado = 1'b0;
        for (int k = 1; k < N_CASILLAS; k++) begin
            idx = {1'b0, cur} + 5'(k);
            if (idx >= 5'(N_CASILLAS)) begin
                idx = idx - 5'(N_CASILLAS);
            end
            if (!hallado && !occ[idx[3:0]]) begin
                res     = idx[3:0];
                hallado = 1'b1;
            end
        end
        return res;
    endfunction

    // State and output registers.
    always_ff @(posedge clk or negedge boton_rst) begin
        if (!boton_rst) begin
            r_estado   <= SELECCION;
            r_contador <= '0;
            r_valida   <= 1'b0;
            r_casilla  <= '0;
        end else begin
            r_estado   <= w_estado_sig;
            r_contador <= w_contador_sig;
            r_valida   <= w_valida_sig;
            r_casilla  <= w_casilla_sig;
        end
    end

    // Next state: select beats move in the same cycle; pulses are discarded while a move is pending.
    always_comb begin
        w_estado_sig   = r_estado;
        w_contador_sig = r_contador;
        w_valida_sig   = r_valida;
        w_casilla_sig  = r_casilla;
        case (r_estado)
            SELECCION: begin
                if (w_p_selec) begin
                    if (!ocupadas[r_contador]) begin
                        w_casilla_sig = r_contador;
                        w_valida_sig  = 1'b1;
                        w_estado_sig  = PENDIENTE;
                    end
                end else if (w_p_mover) begin
                    w_contador_sig = siguiente_libre(r_contador, ocupadas);
                end
            end
            PENDIENTE: begin
                if (jugada_ack) begin
                    w_valida_sig = 1'b0;
                    w_estado_sig = SELECCION;
                end
            end
            default: begin
                w_estado_sig = SELECCION;
            end
        endcase
    end

    assign contador       = r_contador;
    assign jugada_valida  = r_valida;
    assign casilla_jugada = r_casilla;

endmodule

// File: tb/tb_selector_casilla.sv
// Self-checking bench for selector_casilla with DEBOUNCE_CYCLES=4.
// Expected output changes are queued when a press is driven and popped when the outputs change.
// Each queued entry also carries the edge number at which the change must appear.
module tb_selector_casilla;

    localparam int DC = 4;

    logic       clk = 1'b0;
    logic       boton_rst = 1'b0;
    logic       boton_mover = 1'b0;
    logic       boton_selec = 1'b0;
    logic       jugada_ack = 1'b0;
    logic [8:0] ocupadas = '0;
    logic [3:0] contador;
    logic       jugada_valida;
    logic [3:0] casilla_jugada;

    selector_casilla #(.DEBOUNCE_CYCLES(DC)) dut (
        .clk            (clk),
        .boton_rst      (boton_rst),
        .boton_mover    (boton_mover),
        .boton_selec    (boton_selec),
        .ocupadas       (ocupadas),
        .jugada_ack     (jugada_ack),
        .contador       (contador),
        .jugada_valida  (jugada_valida),
        .casilla_jugada (casilla_jugada)
    );

    always #5 clk = ~clk;

    int ciclo = 0;
    always @(posedge clk) ciclo++;

    int errores = 0;
    int comprobaciones = 0;

    task automatic comprobar(input string tag, input int obs, input int esp);
        comprobaciones++;
        if (obs !== esp) begin
            errores++;
            $display("FAIL %s: obtenido=%0d esperado=%0d (ciclo %0d)", tag, obs, esp, ciclo);
        end
    endtask

    typedef struct {
        int cont;
        int val;
        int cas;
        int ciclo;
    } esperado_t;

    esperado_t sb[$];
    esperado_t e_mon;

    // Reference model of the visible state.
    int m_cont = 0;
    int m_val  = 0;
    int m_cas  = 0;

    function automatic int siguiente(input int c, input logic [8:0] occ);
        int n;
        for (int k = 1; k <= 8; k++) begin
            n = (c + k) % 9;
            if (!occ[n]) return n;
        end
        return c;
    endfunction

    task automatic empujar(input int t);
        esperado_t e;
        e.cont  = m_cont;
        e.val   = m_val;
        e.cas   = m_cas;
        e.ciclo = t;
        sb.push_back(e);
    endtask

    // Effect of one debounced pulse set on the model; queues only visible changes.
    task automatic aplicar(input bit mover, input bit selec, input int t);
        int n;
        if (m_val == 0) begin
            if (selec) begin
                if (!ocupadas[m_cont]) begin
                    m_cas = m_cont;
                    m_val = 1;
                    empujar(t);
                end
            end else if (mover) begin
                n = siguiente(m_cont, ocupadas);
                if (n != m_cont) begin
                    m_cont = n;
                    empujar(t);
                end
            end
        end
    endtask

    bit         monitor_on = 1'b0;
    logic [8:0] prev = '0;

    // Every output change must match the head of the queue, at the predicted edge.
    always @(negedge clk) begin
        if (monitor_on && ({contador, jugada_valida, casilla_jugada} !== prev)) begin
            if (sb.size() == 0) begin
                comprobar("cambio_inesperado", int'({contador, jugada_valida, casilla_jugada}), int'(prev));
            end else begin
                e_mon = sb.pop_front();
                comprobar("contador", int'(contador), e_mon.cont);
                comprobar("jugada_valida", int'(jugada_valida), e_mon.val);
                comprobar("casilla_jugada", int'(casilla_jugada), e_mon.cas);
                comprobar("latencia", ciclo, e_mon.ciclo);
            end
            prev = {contador, jugada_valida, casilla_jugada};
        end
    end

    // Clean press: stage 1 samples it at the next edge; result lands DC+3 edges after that.
    task automatic pulsar(input bit mover, input bit selec, input int alto);
        @(negedge clk);
        aplicar(mover, selec, ciclo + 1 + DC + 3);
        boton_mover = mover;
        boton_selec = selec;
        repeat (alto) @(negedge clk);
        boton_mover = 1'b0;
        boton_selec = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic confirmar();
        @(negedge clk);
        jugada_ack = 1'b1;
        if (m_val != 0) begin
            m_val = 0;
            empujar(ciclo + 1);
        end
        @(negedge clk);
        jugada_ack = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic rebote();
        @(negedge clk);
        boton_mover = 1'b1;
        repeat (3) @(negedge clk);
        boton_mover = 1'b0;
        @(negedge clk);
        boton_mover = 1'b1;
        repeat (3) @(negedge clk);
        boton_mover = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic reiniciar();
        monitor_on = 1'b0;
        @(negedge clk);
        boton_rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            boton_mover = i[0];
            boton_selec = ~i[0];
        end
        comprobar("rst_contador", int'(contador), 0);
        comprobar("rst_valida", int'(jugada_valida), 0);
        comprobar("rst_casilla", int'(casilla_jugada), 0);
        boton_mover = 1'b0;
        boton_selec = 1'b0;
        @(negedge clk);
        boton_rst = 1'b1;
        m_cont = 0;
        m_val  = 0;
        m_cas  = 0;
        sb.delete();
        prev = {contador, jugada_valida, casilla_jugada};
        monitor_on = 1'b1;
        repeat (15) @(negedge clk);
    endtask

    task automatic cola_vacia(input string tag);
        repeat (4) @(negedge clk);
        comprobar(tag, sb.size(), 0);
    endtask

    initial begin
        // Reset with buttons toggling, then quiet release.
        reiniciar();
        cola_vacia("cola_reset");

        // Nine moves on an empty board wrap 8 -> 0.
        ocupadas = '0;
        for (int i = 0; i < 9; i++) pulsar(1'b1, 1'b0, 8);
        cola_vacia("cola_vuelta");

        // Skip occupied cells; then only cell 0 free.
        ocupadas = 9'b0_0000_0110;
        pulsar(1'b1, 1'b0, 8);
        ocupadas = 9'h1FE;
        pulsar(1'b1, 1'b0, 8);
        pulsar(1'b1, 1'b0, 8);
        cola_vacia("cola_salto");

        // Bounce gives nothing; a long hold gives exactly one advance.
        ocupadas = '0;
        rebote();
        pulsar(1'b1, 1'b0, 10);
        cola_vacia("cola_rebote");

        // Handshake at cell 4; presses while pending are dropped.
        pulsar(1'b1, 1'b0, 8);
        pulsar(1'b1, 1'b0, 8);
        pulsar(1'b1, 1'b0, 8);
        pulsar(1'b0, 1'b1, 8);
        pulsar(1'b1, 1'b0, 8);
        pulsar(1'b0, 1'b1, 8);
        confirmar();
        confirmar();
        cola_vacia("cola_handshake");

        // Occupied select ignored; full board makes both buttons inert.
        ocupadas = 9'b1_1110_0011;
        pulsar(1'b1, 1'b0, 8);
        ocupadas = 9'b1_1110_0111;
        pulsar(1'b0, 1'b1, 8);
        ocupadas = 9'h1FF;
        pulsar(1'b0, 1'b1, 8);
        pulsar(1'b1, 1'b0, 8);
        cola_vacia("cola_ocupada");

        // Simultaneous move and select at free cell 5: select wins.
        ocupadas = '0;
        pulsar(1'b1, 1'b0, 8);
        pulsar(1'b1, 1'b0, 8);
        pulsar(1'b1, 1'b0, 8);
        pulsar(1'b1, 1'b1, 8);
        cola_vacia("cola_simultaneo");

        // Reset while a move is pending drops it and homes the cursor.
        reiniciar();
        cola_vacia("cola_final");

        $display("Result: errors=%0d of %0d checks", errores, comprobaciones);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: obtenido=timeout esperado=fin");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/selector_casilla.md
# selector_casilla

Cursor controller for the 3x3 board display. Turns the two raw player pushbuttons into a registered cell index `contador` (0–8), which drives the selection-rectangle generator directly. It also hands confirmed moves to the game logic through a valid/ack handshake. The cursor skips cells already marked occupied by the game logic.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable samples needed to accept a new button level (10 ms at 50 MHz).
- `clk` in 1: system clock; all state changes on its rising edge.
- `boton_rst` in 1: reset, asynchronous, active-low.
- `boton_mover` in 1: raw "move" pushbutton, active-high, asynchronous to `clk`.
- `boton_selec` in 1: raw "select" pushbutton, active-high, asynchronous to `clk`.
- `ocupadas` in 9: occupancy mask from game logic; bit i set means cell i is taken.
- `jugada_ack` in 1: game logic has consumed the pending move.
- `contador` out 4: current cursor cell, 0–8, registered.
- `jugada_valida` out 1: a move is pending; held until acknowledged.
- `casilla_jugada` out 4: cell of the pending move; stable while `jugada_valida`=1.

## Operation
- Each button passes through a debounce path:
  - 2-flop synchronizer.
  - Debounce counter: cleared whenever the synchronized value equals the accepted value; otherwise it increments.
  - When the counter reaches `DEBOUNCE_CYCLES`-1, the accepted value flips and the counter clears.
  - A rising edge of the accepted value produces a one-cycle pulse (`p_mover`, `p_selec`). Falling edges produce nothing.
- FSM states: SELECCION and PENDIENTE.
- SELECCION:
  - `p_selec` with `ocupadas[contador]`=0: latch `casilla_jugada`<=`contador`, set `jugada_valida`<=1, go to PENDIENTE.
  - `p_selec` with the cell occupied: ignored.
  - `p_mover`: `contador` <= first i in `contador`+1 … `contador`+8 (mod 9) with `ocupadas[i]`=0. If none exists, `contador` is unchanged. Wrap is 8→0; values 9–15 are never produced.
  - `p_mover` and `p_selec` in the same cycle: select wins and the move is dropped.
- PENDIENTE:
  - `jugada_valida` and `casilla_jugada` are held.
  - All button pulses are discarded; debounce keeps running.
  - `jugada_ack`=1: clear `jugada_valida`, go to SELECCION. `contador` is unchanged.
  - `jugada_ack` in SELECCION is ignored.
- Full board (`ocupadas`=9'h1FF): selects are ignored and moves are no-ops.
- `ocupadas` changes take effect on the next pulse; the cursor is never moved spontaneously.

## Timing
- Reset values (asynchronous, while `boton_rst`=0):
  - `contador`=0, `jugada_valida`=0, `casilla_jugada`=0, state SELECCION.
  - Synchronizers, accepted values and debounce counters all 0.
- Reset mid-operation: a pending move is lost without ack, and the cursor returns to 0.
- Latency, counted from the first high sample at synchronizer stage 1:
  - The accepted value rises `DEBOUNCE_CYCLES`+1 cycles later.
  - The pulse follows 1 cycle after that.
  - `contador` / `jugada_valida` update on the clock edge that ends the pulse cycle.
  - Total: `DEBOUNCE_CYCLES`+3 edges.
- Handshake:
  - `jugada_valida` falls on the edge where `jugada_ack` is sampled high.
  - A new move can register at the earliest one cycle after that.
- A bounce shorter than `DEBOUNCE_CYCLES` consecutive samples produces no pulse.
- A held button gives exactly one pulse.

## Structure
- Package `selector_pkg` holds:
  - `N_CASILLAS`=9.
  - `casilla_t` (`logic [3:0]`).
  - State enum `estado_t` {SELECCION, PENDIENTE}.
- Sub-module `antirrebote` (synchronizer, debounce counter, rising-edge pulse), parameterized by `DEBOUNCE_CYCLES` and instantiated twice.
- The next-free-cell search is a combinational function in the top module.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4.
- Reset: hold `boton_rst`=0 with buttons toggling -> `contador`=0, `jugada_valida`=0; release -> no pulse until a debounced edge.
- Move wrap: `ocupadas`=0, nine clean `boton_mover` presses -> `contador` steps 1,2,…,8,0, each change exactly 7 edges after the press reaches stage 1.
- Skip occupied: `ocupadas`=9'b0_0000_0110, `contador`=0, press move -> `contador`=3; with 9'h1FE at `contador`=0, press move -> stays 0.
- Bounce rejection: `boton_mover` high 3 cycles, low 1, high 3 -> no change; then held 10 cycles -> exactly one advance.
- Handshake: `contador`=4 free, press select -> `jugada_valida`=1, `casilla_jugada`=4. Move/select presses while pending are ignored. Pulse `jugada_ack` -> `jugada_valida`=0 next edge, `contador`=4.
- Occupied select and simultaneous events:
  - `ocupadas[2]`=1, `contador`=2, press select -> no `jugada_valida`.
  - Move and select edges in the same cycle at free cell 5 -> move to 5 latched, `contador` stays 5.
